// File: rtl/mic3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mic3_pkg
//  Description : Shared frame geometry and state encoding for the Pmod MIC3
//                converter emulator (SPI responder).
//                Contents:
//                  LEAD_ZEROS  zero bits sent ahead of the sample
//                  DATA_BITS   sample width
//                  FRAME_BITS  total bits per frame
//                  CNT_W       width of the falling-edge counter
//                  state_t     responder states IDLE / SHIFT / TRAIL
//  Revision    : 1.0  initial release
// ============================================================================
package mic3_pkg;

  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mic3_adc_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mic3_adc_responder_if
//  Description : SPI pins plus sample-feed and status signals of the MIC3
//                responder.
//                Signals:
//                  SCLK, CS      SPI clock (idles high) / chip select (low)
//                  MISO, MISO_en serial data and its drive enable
//                  sample        12-bit sample, sample_valid write strobe
//                  frame_done, short_frame, underrun   1-cycle status pulses
//                  busy          high while a frame is being served
//                Modports: slave = responder side, master = initiator/feeder.
//  Revision    : 1.0  initial release
// ============================================================================
interface mic3_adc_responder_if;
  import mic3_pkg::*;

  logic                 SCLK;
  logic                 CS;
  logic                 MISO;
  logic                 MISO_en;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 frame_done;
  logic                 short_frame;
  logic                 underrun;
  logic                 busy;

  modport slave (
    input  SCLK, CS, sample, sample_valid,
    output MISO, MISO_en, frame_done, short_frame, underrun, busy
  );

  modport master (
    output SCLK, CS, sample, sample_valid,
    input  MISO, MISO_en, frame_done, short_frame, underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/mic3_adc_responder_spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Multi-flop synchronizer for one SPI pin plus an edge detector.
//                Ports:
//                  clk, rst   system clock, synchronous active-high reset
//                  i_pin      asynchronous pin
//                  o_level    synchronized level
//                  o_rise     1-cycle strobe on a synchronized 0->1
//                  o_fall     1-cycle strobe on a synchronized 1->0
//                All flops reset to 1, the idle level of SCLK and CS.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = ~r_prev &  r_sync[SYNC_STAGES-1];
  assign o_fall  =  r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mic3_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mic3_adc_responder
//  Description : Emulates the Pmod MIC3 converter on the far side of an SPI
//                link. Each frame is LEAD_ZEROS zeros then a DATA_BITS sample,
//                MSB first, advanced on SCLK falling edges. The SPI pins are
//                oversampled on clk (clk must be >= 4x SCLK).
//                Ports:
//                  clk, rst   system clock, synchronous active-high reset
//                  bus        mic3_adc_responder_if.slave (SPI pins, sample
//                             feed, status pulses, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module mic3_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mic3_adc_responder_if.slave   bus
);
  import mic3_pkg::*;

  localparam int FILL_W = $clog2(SYNC_STAGES + 1) + 1;

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused_sclk;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (bus.SCLK),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (bus.CS),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_unused_sclk = w_sclk_level ^ w_sclk_rise;

  state_t                r_state,  w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift,  w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
  logic [DATA_BITS-1:0]  r_hold,   w_hold_nxt;
  logic                  r_fresh,  w_fresh_nxt;
  logic                  r_done,   w_done_nxt;
  logic                  r_short,  w_short_nxt;
  logic                  r_under,  w_under_nxt;
  logic                  r_armed,  w_armed_nxt;
  logic [FILL_W-1:0]     r_fill;
  logic                  w_start;
  logic [DATA_BITS-1:0]  w_sample_in;

  // The synchronizers reload idle-high on reset, so a CS already held low
  // would look like a fresh fall once the chain refills. r_fill counts how
  // many real pin samples have entered the chain; the responder only arms
  // after a genuine high level on CS has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
    end else if (r_fill != FILL_W'(SYNC_STAGES)) begin
      r_fill <= r_fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_fresh <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
      r_under <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_fresh <= w_fresh_nxt;
      r_done  <= w_done_nxt;
      r_short <= w_short_nxt;
      r_under <= w_under_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // A same-cycle sample_valid wins over the stored value for the frame load.
  assign w_sample_in = bus.sample_valid ? bus.sample : r_hold;
  assign w_start     = (r_state == IDLE) && w_cs_fall && r_armed;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = w_sample_in;
    w_fresh_nxt = bus.sample_valid ? 1'b1 : r_fresh;
    w_done_nxt  = 1'b0;
    w_short_nxt = 1'b0;
    w_under_nxt = 1'b0;
    w_armed_nxt = r_armed | ((r_fill == FILL_W'(SYNC_STAGES)) & w_cs_level);

    case (r_state)
      IDLE: begin
        // A coincident sclk_fall is deliberately not counted here.
        if (w_start) begin
          w_shift_nxt = {{LEAD_ZEROS{1'b0}}, w_sample_in};
          w_cnt_nxt   = '0;
          w_under_nxt = ~(r_fresh | bus.sample_valid);
          w_fresh_nxt = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_short_nxt = 1'b1;
          w_shift_nxt = '0;
          w_state_nxt = IDLE;
        end else if (w_sclk_fall) begin
          // Zero fill means MISO reads 0 once all frame bits are out.
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
            w_state_nxt = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (w_cs_rise) begin
          w_done_nxt  = 1'b1;
          w_shift_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_shift_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.MISO        = r_shift[FRAME_BITS-1];
  assign bus.MISO_en     = (r_state != IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.frame_done  = r_done;
  assign bus.short_frame = r_short;
  assign bus.underrun    = r_under;

endmodule
`default_nettype wire
